// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fs_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, skid-buffers a
// word that returns under stall, and drains an outstanding request on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(fetch_stage_pkg::RESET_PC),
  parameter int unsigned     INSTR_BYTES = fetch_stage_pkg::INSTR_BYTES
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_data,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic [XLEN-1:0] o_instr,
  output logic            o_valid
);

  fs_state_t       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_tgt, w_tgt_nxt;
  logic [XLEN-1:0] r_buf, w_buf_nxt;
  logic [XLEN-1:0] r_opc, w_opc_nxt;
  logic [XLEN-1:0] r_opc4, w_opc4_nxt;
  logic [XLEN-1:0] r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic [XLEN-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + XLEN'(INSTR_BYTES);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_buf_nxt   = r_buf;
    w_opc_nxt   = r_opc;
    w_opc4_nxt  = r_opc4;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    case (r_state)
      FS_BOOT: w_state_nxt = FS_FETCH;
      FS_FETCH: begin
        if (i_redirect) begin
          w_valid_nxt = 1'b0;
          if (i_imem_ack) begin
            w_pc_nxt = i_redirect_pc;
          end else begin
            w_tgt_nxt   = i_redirect_pc;
            w_state_nxt = FS_DRAIN;
          end
        end else if (i_imem_ack) begin
          if (!i_stall) begin
            w_instr_nxt = i_imem_data;
            w_opc_nxt   = r_pc;
            w_opc4_nxt  = w_pc_inc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end else begin
            w_buf_nxt   = i_imem_data;
            w_state_nxt = FS_HOLD;
          end
        end else if (!i_stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      FS_HOLD: begin
        if (i_redirect) begin
          w_pc_nxt    = i_redirect_pc;
          w_valid_nxt = 1'b0;
          w_state_nxt = FS_FETCH;
        end else if (!i_stall) begin
          w_instr_nxt = r_buf;
          w_opc_nxt   = r_pc;
          w_opc4_nxt  = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = FS_FETCH;
        end
      end
      FS_DRAIN: begin
        // The returning word belongs to the abandoned path; only the latest target matters.
        w_valid_nxt = 1'b0;
        if (i_imem_ack) begin
          w_pc_nxt    = i_redirect ? i_redirect_pc : r_tgt;
          w_state_nxt = FS_FETCH;
        end else if (i_redirect) begin
          w_tgt_nxt = i_redirect_pc;
        end
      end
      default: w_state_nxt = FS_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= FS_BOOT;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_buf   <= '0;
      r_opc   <= '0;
      r_opc4  <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_buf   <= w_buf_nxt;
      r_opc   <= w_opc_nxt;
      r_opc4  <= w_opc4_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_imem_req  = (r_state == FS_FETCH) || (r_state == FS_DRAIN);
  assign o_imem_addr = r_pc;
  assign o_pc        = r_opc;
  assign o_pc4       = r_opc4;
  assign o_instr     = r_instr;
  assign o_valid     = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected instructions are queued as acks are
// driven and popped whenever the downstream register accepts a valid output.
module tb_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_data = '0;
  logic [31:0] o_pc, o_pc4, o_instr;
  logic        o_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0040_0000), .INSTR_BYTES(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .o_pc(o_pc), .o_pc4(o_pc4), .o_instr(o_instr), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.pc4 = pc + 32'd4;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic ack, input logic [31:0] data, input logic st,
                     input logic rd, input logic [31:0] rpc);
    i_imem_ack = ack;
    i_imem_data = data;
    i_stall = st;
    i_redirect = rd;
    i_redirect_pc = rpc;
    @(posedge i_clk);
    #1;
  endtask

  // An output with stall low at this point is written into IF/ID on the next edge.
  always @(negedge i_clk) begin
    if (i_reset_n && o_valid === 1'b1 && !i_stall) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed pc=%h instr=%h expected none", o_pc, o_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", o_pc, e.pc);
        chk("sb_pc4", o_pc4, e.pc4);
        chk("sb_instr", o_instr, e.instr);
      end
    end
  end

  initial begin
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Boot idle cycle, then back-to-back zero-wait fetches.
    chk("boot_req", {31'd0, o_imem_req}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("f0_req", {31'd0, o_imem_req}, 32'd1);
    chk("f0_addr", o_imem_addr, 32'h0040_0000);
    push(32'h0040_0000, 32'hA000_0000);
    cyc(1'b1, 32'hA000_0000, 1'b0, 1'b0, '0);
    chk("f0_valid", {31'd0, o_valid}, 32'd1);
    chk("f0_pc", o_pc, 32'h0040_0000);
    chk("f0_pc4", o_pc4, 32'h0040_0004);
    chk("f1_addr", o_imem_addr, 32'h0040_0004);
    push(32'h0040_0004, 32'hA000_0001);
    cyc(1'b1, 32'hA000_0001, 1'b0, 1'b0, '0);
    chk("f2_addr", o_imem_addr, 32'h0040_0008);
    push(32'h0040_0008, 32'hA000_0002);
    cyc(1'b1, 32'hA000_0002, 1'b0, 1'b0, '0);

    // Ack under stall lands in the skid buffer; stall held three cycles.
    push(32'h0040_000C, 32'hDEAD_BEEF);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    chk("hold_req", {31'd0, o_imem_req}, 32'd0);
    chk("hold_instr", o_instr, 32'hA000_0002);
    chk("hold_valid", {31'd0, o_valid}, 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    chk("hold3_instr", o_instr, 32'hA000_0002);
    chk("hold3_req", {31'd0, o_imem_req}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("rel_instr", o_instr, 32'hDEAD_BEEF);
    chk("rel_valid", {31'd0, o_valid}, 32'd1);
    chk("rel_pc", o_pc, 32'h0040_000C);
    chk("rel_addr", o_imem_addr, 32'h0040_0010);

    // Redirect with a request outstanding: drain the stale word.
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h0040_0100);
    chk("drain_valid", {31'd0, o_valid}, 32'd0);
    chk("drain_addr", o_imem_addr, 32'h0040_0010);
    chk("drain_req", {31'd0, o_imem_req}, 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("drain2_valid", {31'd0, o_valid}, 32'd0);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, '0);
    chk("drain_done_valid", {31'd0, o_valid}, 32'd0);
    chk("stale_not_out", {31'd0, (o_instr == 32'h1234_5678)}, 32'd0);
    chk("tgt_addr", o_imem_addr, 32'h0040_0100);
    push(32'h0040_0100, 32'hB000_0000);
    cyc(1'b1, 32'hB000_0000, 1'b0, 1'b0, '0);
    chk("tgt_instr", o_instr, 32'hB000_0000);

    // Redirect together with stall while in HOLD: buffer and held output are flushed.
    cyc(1'b1, 32'hB000_0001, 1'b1, 1'b0, '0);
    chk("hold2_req", {31'd0, o_imem_req}, 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h0040_0200);
    void'(sb.pop_front());
    chk("hflush_valid", {31'd0, o_valid}, 32'd0);
    chk("hflush_addr", o_imem_addr, 32'h0040_0200);
    chk("hflush_req", {31'd0, o_imem_req}, 32'd1);
    push(32'h0040_0200, 32'hC000_0000);
    cyc(1'b1, 32'hC000_0000, 1'b0, 1'b0, '0);
    chk("hflush_instr", o_instr, 32'hC000_0000);

    // Redirect accompanied by ack (word dropped), then PC wraps past the top.
    cyc(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_rd_valid", {31'd0, o_valid}, 32'd0);
    chk("wrap_rd_addr", o_imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'hD000_0000);
    cyc(1'b1, 32'hD000_0000, 1'b0, 1'b0, '0);
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", o_pc4, 32'h0000_0000);
    chk("wrap_addr", o_imem_addr, 32'h0000_0000);
    push(32'h0000_0000, 32'hD000_0001);
    cyc(1'b1, 32'hD000_0001, 1'b0, 1'b0, '0);
    chk("wrap2_pc", o_pc, 32'h0000_0000);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("bubble_valid", {31'd0, o_valid}, 32'd0);

    // Async reset in the middle of a drain; a late ack must be ignored.
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h0040_0300);
    chk("drain3_addr", o_imem_addr, 32'h0000_0004);
    #2 i_reset_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, o_valid}, 32'd0);
    chk("mrst_req", {31'd0, o_imem_req}, 32'd0);
    chk("mrst_pc", o_pc, 32'd0);
    chk("mrst_pc4", o_pc4, 32'd0);
    chk("mrst_instr", o_instr, 32'd0);
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, '0);
    i_reset_n = 1'b1;
    chk("mrst_boot_req", {31'd0, o_imem_req}, 32'd0);
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, '0);
    chk("restart_valid", {31'd0, o_valid}, 32'd0);
    chk("restart_addr", o_imem_addr, 32'h0040_0000);
    push(32'h0040_0000, 32'hF000_0000);
    cyc(1'b1, 32'hF000_0000, 1'b0, 1'b0, '0);
    chk("restart_instr", o_instr, 32'hF000_0000);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage at the head of the pipeline.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Presents {pc, pc+4, instruction, valid} to the IF/ID pipeline register, whose write enable is driven with !stall.
- Honours stall from the hazard unit and redirect from branch/jump resolution. A skid buffer holds a word that returns while stalled.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- INSTR_BYTES, 4, PC increment per instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- stall  in  1  downstream cannot accept; outputs must hold.
- redirect  in  1  flush and load new PC.
- redirect_pc  in  XLEN  target when redirect=1.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request word address.
- imem_ack  in  1  data valid this cycle; completes the request.
- imem_data  in  XLEN  instruction word.
- out_pc  out  XLEN  PC of presented instruction.
- out_pc4  out  XLEN  out_pc + INSTR_BYTES.
- out_instr  out  XLEN  instruction word.
- out_valid  out  1  presented instruction is real (0 = bubble).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=BOOT.
  - out_pc, out_pc4, out_instr, buf = 0; out_valid=0; imem_req=0.
- Priority at every edge: reset > redirect > stall.
- Memory contract:
  - imem_addr equals the registered pc and must stay stable while imem_req=1 until imem_ack.
  - imem_ack is only sampled while imem_req=1.
  - Zero-wait memory may ack in the same cycle as req (1 instr/cycle throughput).
- All outputs are registered. imem_req and imem_addr are decoded from state and pc only.
- States:
  - BOOT: req=0. Next edge goes to FETCH. Gives one idle cycle after reset release.
  - FETCH: req=1, addr=pc. Transitions:
    - ack & redirect: drop data; pc<=redirect_pc; out_valid<=0; stay FETCH.
    - !ack & redirect: request still outstanding. tgt<=redirect_pc; out_valid<=0; go DRAIN.
    - ack & !stall: out_instr<=data, out_pc<=pc, out_pc4<=pc+4, out_valid<=1; pc<=pc+4; stay FETCH.
    - ack & stall: buf<=data; outputs hold; go HOLD.
    - !ack & !stall: out_valid<=0 (bubble); other outputs may hold.
    - !ack & stall: outputs hold.
  - HOLD: req=0. Transitions:
    - redirect: discard buf; pc<=redirect_pc; out_valid<=0; go FETCH.
    - !stall: load outputs from buf and pc (as in FETCH ack & !stall); pc<=pc+4; go FETCH.
    - stall: hold.
  - DRAIN: req=1, addr=old pc. The returning word is discarded and never reaches outputs. Transitions:
    - Further redirect: tgt<=redirect_pc (latest wins); out_valid stays 0.
    - ack: pc<=tgt (or redirect_pc if redirect is asserted the same cycle); go FETCH.
- Flush beats stall: redirect forces out_valid<=0 even when stall=1.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 silently. No alignment checking; redirect_pc[1:0] is passed through unchanged.
- Reset mid-request (any state): immediate return to BOOT. Any later ack for the abandoned request is ignored because req=0 in BOOT.

Decomposition:
- Shared pipeline package holds:
  - State encodings FS_BOOT=2'd0, FS_FETCH=2'd1, FS_HOLD=2'd2, FS_DRAIN=2'd3.
  - RESET_PC and INSTR_BYTES constants, reused by the decode/branch stages.
- No sub-module. The output register is local to the block. The downstream IF/ID register stays the existing generic flop.

Test Plan:
- Reset release, memory acks every cycle, no stall:
  - imem_req=0 for one cycle, then addresses 0x00400000, 0x00400004, 0x00400008.
  - out_valid rises one cycle after the first ack, with out_pc=0x00400000 and out_pc4=0x00400004.
- Ack with data 0xDEADBEEF while stall=1, stall held 3 cycles:
  - imem_req=0 during HOLD; outputs frozen at previous instruction.
  - On release: out_instr=0xDEADBEEF, out_valid=1, next addr = +4.
- Redirect to 0x00400100 while a request is outstanding (no ack), ack 2 cycles later with 0x12345678:
  - out_valid=0 from the next edge.
  - 0x12345678 never appears on out_instr.
  - Next request addr = 0x00400100.
- Redirect and stall both asserted in HOLD:
  - out_valid=0 next edge; buf discarded; addr = redirect_pc.
- Redirect to 0xFFFFFFFC, two acks:
  - out_pc=0xFFFFFFFC, out_pc4=0x00000000; second fetch addr = 0x00000000.
- reset pulsed low mid-DRAIN:
  - All outputs 0 immediately (async).
  - A late ack pulse is ignored; fetch restarts at 0x00400000 after BOOT.
